// File: rtl/sequential_divider_pkg.sv
// div_pkg: shared width, FSM states and constants for the sequential divider.
// Build option: SEQDIV_UNSIGNED_EN adds a signed_op input to the divider top.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int ITER_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOT = '1;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/sequential_divider_step.sv
// div_step: one restoring radix-2 division step (combinational).
// Ports: rem (partial remainder), dvd_msb (next dividend bit), divisor (magnitude),
//        next_rem (updated remainder), q_bit (quotient bit produced this step).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] w_shift;
    // One extra bit so a remainder with its top bit set still compares correctly.
    assign w_shift  = {rem, dvd_msb};
    assign q_bit    = w_shift >= {1'b0, divisor};
    assign next_rem = q_bit ? WIDTH'(w_shift - {1'b0, divisor}) : w_shift[WIDTH-1:0];
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle signed restoring divider, one quotient bit per clock.
// Ports: clk, rst_n (async active-low); start/dividend/divisor request inputs;
//        busy, done (one-cycle pulse), quotient, remainder, div_by_zero results.
// Build option: SEQDIV_UNSIGNED_EN adds signed_op (0 = unsigned operation).
module sequential_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SEQDIV_UNSIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int IW = $clog2(WIDTH);
    state_t           r_state;
    logic [IW-1:0]    r_iter;
    logic [WIDTH-1:0] r_rem, r_dvd, r_dsr;
    logic             r_sign_q, r_sign_r;
    logic             w_signed, w_neg_a, w_neg_b, w_dbz, w_q_bit;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_next_rem;
`ifdef SEQDIV_UNSIGNED_EN
    assign w_signed = signed_op;
`else
    assign w_signed = 1'b1;
`endif
    assign w_neg_a = w_signed & dividend[WIDTH-1];
    assign w_neg_b = w_signed & divisor[WIDTH-1];
    assign w_abs_a = w_neg_a ? -dividend : dividend;
    assign w_abs_b = w_neg_b ? -divisor : divisor;
    assign w_dbz   = divisor == '0;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .divisor (r_dsr),
        .next_rem(w_next_rem),
        .q_bit   (w_q_bit)
    );
    // r_dvd doubles as the quotient register: dividend bits shift out the top
    // while quotient bits shift in at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_iter      <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dsr       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_rem       <= '0;
                        r_iter      <= '0;
                        r_dsr       <= w_abs_b;
                        r_dvd       <= w_dbz ? dividend : w_abs_a;
                        r_sign_q    <= w_neg_a ^ w_neg_b;
                        r_sign_r    <= w_neg_a;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= w_dbz ? DONE : RUN;
                    end
                end
                RUN: begin
                    r_rem  <= w_next_rem;
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == IW'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    quotient  <= r_sign_q ? -r_dvd : r_dvd;
                    remainder <= r_sign_r ? -r_rem : r_rem;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= DONE;
                end
                default: begin
                    // Arrival from FIX already raised done; arrival straight from
                    // IDLE (divide by zero) raises it here, one cycle later.
                    if (done) begin
                        done    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        quotient    <= WIDTH'(DIV_BY_ZERO_QUOT);
                        remainder   <= r_dvd;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_divider.sv
// tb_sequential_divider: randomized self-checking bench for sequential_divider.
module tb_sequential_divider;
    logic        clk, rst_n, start, busy, done, div_by_zero;
    logic [31:0] dividend, divisor, quotient, remainder;
`ifdef SEQDIV_UNSIGNED_EN
    logic        signed_op;
`endif
    int n_checks = 0;
    int n_fail = 0;

    sequential_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef SEQDIV_UNSIGNED_EN
        .signed_op(signed_op),
`endif
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: exact 64-bit arithmetic, C-style truncation toward zero.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output logic [31:0] q, output logic [31:0] r, output bit z);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; z = 1;
        end else begin
            sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
            q = 32'(sa / sb); r = 32'(sa % sb); z = 0;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] eq, er, q0, r0;
        bit ez, hold_ok, busy_ok;
        int dc, edc;
        model(a, b, sgn, eq, er, ez);
        edc = ez ? 2 : 34;
        q0 = quotient; r0 = remainder;
        @(negedge clk);
        dividend = a; divisor = b; start = 1;
`ifdef SEQDIV_UNSIGNED_EN
        signed_op = sgn;
`endif
        @(posedge clk); #1;
        start = 0; dividend = $urandom; divisor = $urandom;
        dc = 0; hold_ok = 1; busy_ok = 1;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (done) dc = c;
            else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (quotient !== q0 || remainder !== r0) hold_ok = 0;
            end
        end
        n_checks++; if (dc !== edc) begin n_fail++; $display("FAIL latency %h/%h: got cycle %0d expected %0d", a, b, dc, edc); end
        n_checks++; if (quotient !== eq) begin n_fail++; $display("FAIL quotient %h/%h: got %h expected %h", a, b, quotient, eq); end
        n_checks++; if (remainder !== er) begin n_fail++; $display("FAIL remainder %h/%h: got %h expected %h", a, b, remainder, er); end
        n_checks++; if (div_by_zero !== ez) begin n_fail++; $display("FAIL div_by_zero %h/%h: got %b expected %b", a, b, div_by_zero, ez); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done %h/%h: got %b expected 0", a, b, busy); end
        n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL busy_while_running %h/%h: got drop expected 1", a, b); end
        n_checks++; if (!hold_ok) begin n_fail++; $display("FAIL result_hold %h/%h: got change expected %h/%h", a, b, q0, r0); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse %h/%h: got %b expected 0", a, b, done); end
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
        n_checks++; if ({quotient, remainder} !== 64'd0) begin n_fail++; $display("FAIL reset_results: got %h expected 0", {quotient, remainder}); end
        @(negedge clk); rst_n = 1;
        repeat (2) @(posedge clk); #1;
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_signed();
        run_op(32'd100, 32'd7, 1);
        n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL 100_div_7: got %0d r %0d expected 14 r 2", quotient, remainder); end
        run_op(-32'sd100, 32'd7, 1);
        n_checks++; if (quotient !== 32'hFFFF_FFF2 || remainder !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL neg100_div_7: got %h r %h expected fffffff2 r fffffffe", quotient, remainder); end
        run_op(32'd100, -32'sd7, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1);
        n_checks++; if (quotient !== 32'h8000_0000 || remainder !== 0) begin n_fail++; $display("FAIL overflow: got %h r %h expected 80000000 r 0", quotient, remainder); end
        run_op(32'h8000_0000, 32'd1, 1);
        run_op(32'd0, 32'h8000_0000, 1);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1);
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, 1);
        n_checks++; if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0: got %h r %h z %b expected ffffffff r 5 z 1", quotient, remainder, div_by_zero); end
        run_op(32'd9, 32'd3, 1);
        run_op(32'h8000_0000, 32'd0, 1);
    endtask

    task automatic test_start_ignored();
        int dc, extra;
        @(negedge clk); dividend = 100; divisor = 7; start = 1;
`ifdef SEQDIV_UNSIGNED_EN
        signed_op = 1;
`endif
        @(posedge clk); #1; start = 0;
        dc = 0; extra = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 9) begin dividend = 50; divisor = 5; start = 1; end
            if (c == 10) start = 0;
            if (done && dc == 0) dc = c;
            else if (done) extra++;
        end
        n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL ignored_start_latency: got %0d expected 34", dc); end
        n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin n_fail++; $display("FAIL ignored_start_result: got %0d r %0d expected 14 r 2", quotient, remainder); end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignored_start_queued: got %0d extra done expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk); dividend = 1234; divisor = 5; start = 1;
`ifdef SEQDIV_UNSIGNED_EN
        signed_op = 1;
`endif
        @(posedge clk); #1; start = 0;
        repeat (14) @(posedge clk);
        #2 rst_n = 0; #1;
        n_checks++; if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== 64'd0) begin n_fail++; $display("FAIL mid_reset_outputs: got %b %h %h expected zeros", {busy, done, div_by_zero}, quotient, remainder); end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) seen++; end
        @(negedge clk); rst_n = 1;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_done: got %0d done pulses expected 0", seen); end
        run_op(32'd1000, 32'd33, 1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 150; i++) begin
            a = (i % 17 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'hFFFF_FFFF;
            endcase
            run_op(a, b, 1);
        end
    endtask

`ifdef SEQDIV_UNSIGNED_EN
    task automatic test_unsigned();
        run_op(32'hFFFF_FFFF, 32'd2, 0);
        n_checks++; if (quotient !== 32'h7FFF_FFFF || remainder !== 32'd1) begin n_fail++; $display("FAIL unsigned: got %h r %h expected 7fffffff r 1", quotient, remainder); end
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(32'd7, 32'd0, 0);
        for (int i = 0; i < 40; i++) run_op($urandom, $urandom >> $urandom_range(0, 31), $urandom_range(0, 1) == 1);
    endtask
`endif

    initial begin
        clk = 0; rst_n = 0; start = 0; dividend = 0; divisor = 0;
`ifdef SEQDIV_UNSIGNED_EN
        signed_op = 1;
`endif
        test_reset();
        test_signed();
        test_div_zero();
        test_start_ignored();
        test_reset_mid();
        test_random();
`ifdef SEQDIV_UNSIGNED_EN
        test_unsigned();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
